// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared types and constants for the register-file write-back controller.
// Holds the register file geometry, the write-back source ids and a one-hot decode helper.
package regfile_wb_ctrl_pkg;

  localparam int REG_W   = 32;
  localparam int REG_AW  = 5;
  localparam int REG_NUM = 32;

  localparam logic [REG_W-1:0] ZERO_WORD = '0;
  localparam logic             WRITE_EN  = 1'b1;

  localparam int WB_SRC_NUM = 3;
  localparam int WB_SRC_ALU = 0;
  localparam int WB_SRC_LSU = 1;
  localparam int WB_SRC_MDU = 2;

  // r0 is hardwired, so its scoreboard bit never decodes
  function automatic logic [REG_NUM-1:0] dec_reg(
    input logic [REG_AW-1:0] a
  );
    logic [REG_NUM-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    v[0] = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Generic N-way arbiter: one-hot grant, round-robin or fixed priority.
// Ports: i_clk, i_rst (sync high), i_req[N], i_en (grant consumed), o_gnt[N].
module rr_arbiter #(
  parameter int N     = 2,
  parameter int FIXED = 0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_req,
  input  logic         i_en,
  output logic [N-1:0] o_gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_nxt;
  logic [N-1:0]  w_gnt;

  // search begins at the pointer; fixed mode always starts at 0
  always_comb begin
    int   idx;
    logic found;
    w_gnt = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 0; off < N; off++) begin
      if (FIXED != 0) begin
        idx = off;
      end else begin
        idx = int'(r_ptr) + off;
        if (idx >= N) idx = idx - N;
      end
      if (!found && i_req[idx]) begin
        w_gnt[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    w_ptr_nxt = r_ptr;
    for (int i = 0; i < N; i++) begin
      if (w_gnt[i]) begin
        w_ptr_nxt = (i == N - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (i_en && |w_gnt) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  assign o_gnt = w_gnt;

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: arbitrates producers onto the regfile write port and tracks pending writes.
// Ports: src_* producer handshake, iss_* destination claim, chk/busy hazard lookup, we/waddr/wdata to regfile.
module regfile_wb_ctrl
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int N_SRC     = WB_SRC_NUM,
  parameter int PRIO_MODE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_SRC-1:0]        src_valid,
  output logic [N_SRC-1:0]        src_ready,
  input  logic [N_SRC*REG_AW-1:0] src_addr,
  input  logic [N_SRC*REG_W-1:0]  src_data,
  input  logic                    iss_valid,
  input  logic [REG_AW-1:0]       iss_addr,
  output logic                    iss_ready,
  input  logic [REG_AW-1:0]       chk_addr1,
  input  logic [REG_AW-1:0]       chk_addr2,
  output logic                    busy1,
  output logic                    busy2,
  output logic [REG_NUM-1:0]      busy_vec,
  output logic                    we,
  output logic [REG_AW-1:0]       waddr,
  output logic [REG_W-1:0]        wdata
);

  logic [N_SRC-1:0]   w_gnt;
  logic [N_SRC-1:0]   w_hs;
  logic               w_hs_any;
  logic [REG_AW-1:0]  w_win_addr;
  logic [REG_W-1:0]   w_win_data;
  logic               w_iss_fire;
  logic [REG_NUM-1:0] w_set;
  logic [REG_NUM-1:0] w_clr;

  logic [REG_NUM-1:0] r_busy;
  logic               r_we;
  logic [REG_AW-1:0]  r_waddr;
  logic [REG_W-1:0]   r_wdata;

  rr_arbiter #(
    .N     (N_SRC),
    .FIXED (PRIO_MODE)
  ) u_arb (
    .i_clk (clk),
    .i_rst (rst),
    .i_req (src_valid),
    .i_en  (~rst),
    .o_gnt (w_gnt)
  );

  assign src_ready = rst ? '0 : w_gnt;
  assign w_hs      = src_valid & src_ready;
  assign w_hs_any  = |w_hs;

  // one-hot mux of the winning producer
  always_comb begin
    w_win_addr = '0;
    w_win_data = ZERO_WORD;
    for (int i = 0; i < N_SRC; i++) begin
      if (w_hs[i]) begin
        w_win_addr = src_addr[i*REG_AW +: REG_AW];
        w_win_data = src_data[i*REG_W +: REG_W];
      end
    end
  end

  // registered busy only, so a WAW claim waits for the older write
  assign iss_ready  = ~rst & ~r_busy[iss_addr];
  assign w_iss_fire = iss_valid & iss_ready;
  assign w_set      = w_iss_fire ? dec_reg(iss_addr) : '0;
  assign w_clr      = w_hs_any ? dec_reg(w_win_addr) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= ZERO_WORD;
    end else if (w_hs_any) begin
      r_we    <= (w_win_addr != '0) ? WRITE_EN : 1'b0;
      r_waddr <= w_win_addr;
      r_wdata <= w_win_data;
    end else begin
      r_we <= 1'b0;
    end
  end

  assign busy1    = ~rst & r_busy[chk_addr1];
  assign busy2    = ~rst & r_busy[chk_addr2];
  assign busy_vec = r_busy;
  assign we       = r_we;
  assign waddr    = r_waddr;
  assign wdata    = r_wdata;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: one round-robin and one fixed-priority instance.
// Both share stimulus; each scenario checks the instance it targets.
module tb_regfile_wb_ctrl;
  import regfile_wb_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  src_valid;
  logic [14:0] src_addr;
  logic [95:0] src_data;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic [4:0]  chk_addr1;
  logic [4:0]  chk_addr2;

  logic [2:0]  rr_ready, fp_ready;
  logic        rr_iss_rdy, fp_iss_rdy;
  logic        rr_busy1, rr_busy2, fp_busy1, fp_busy2;
  logic [31:0] rr_bvec, fp_bvec;
  logic        rr_we, fp_we;
  logic [4:0]  rr_waddr, fp_waddr;
  logic [31:0] rr_wdata, fp_wdata;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  regfile_wb_ctrl #(.N_SRC(3), .PRIO_MODE(0)) dut_rr (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_ready(rr_ready),
    .src_addr(src_addr), .src_data(src_data),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .iss_ready(rr_iss_rdy),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .busy1(rr_busy1), .busy2(rr_busy2),
    .busy_vec(rr_bvec),
    .we(rr_we), .waddr(rr_waddr), .wdata(rr_wdata)
  );

  regfile_wb_ctrl #(.N_SRC(3), .PRIO_MODE(1)) dut_fp (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_ready(fp_ready),
    .src_addr(src_addr), .src_data(src_data),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .iss_ready(fp_iss_rdy),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .busy1(fp_busy1), .busy2(fp_busy2),
    .busy_vec(fp_bvec),
    .we(fp_we), .waddr(fp_waddr), .wdata(fp_wdata)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input logic [2:0] v,
                         input logic [4:0] a0, input logic [4:0] a1,
                         input logic [4:0] a2,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2);
    src_valid = v;
    src_addr  = {a2, a1, a0};
    src_data  = {d2, d1, d0};
  endtask

  initial begin
    rst       = 1'b1;
    set_src(3'b111, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3);
    iss_valid = 1'b1;
    iss_addr  = 5'd3;
    chk_addr1 = 5'd0;
    chk_addr2 = 5'd0;

    // 1: reset with requests pending, all outputs held quiet
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_we", 32'(rr_we), 32'd0);
      chk("rst_bvec", rr_bvec, 32'd0);
      chk("rst_ready", 32'(rr_ready), 32'd0);
      chk("rst_iss", 32'(rr_iss_rdy), 32'd0);
    end
    rst = 1'b0;
    set_src(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    iss_valid = 1'b0;
    tick();

    // 2: claim r5, ALU writes it two edges later
    iss_valid = 1'b1;
    iss_addr  = 5'd5;
    chk_addr1 = 5'd5;
    #1;
    chk("t2_iss_rdy", 32'(rr_iss_rdy), 32'd1);
    chk("t2_busy1_pre", 32'(rr_busy1), 32'd0);
    tick();
    iss_valid = 1'b0;
    #1;
    chk("t2_busy1", 32'(rr_busy1), 32'd1);
    chk("t2_bvec", rr_bvec, 32'h0000_0020);
    tick();
    set_src(3'b001, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0);
    #1;
    chk("t2_ready", 32'(rr_ready), 32'b001);
    tick();
    set_src(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    #1;
    chk("t2_we", 32'(rr_we), 32'd1);
    chk("t2_waddr", 32'(rr_waddr), 32'd5);
    chk("t2_wdata", rr_wdata, 32'hDEADBEEF);
    chk("t2_busy1_clr", 32'(rr_busy1), 32'd0);

    // brief reset so the round-robin pointer restarts at 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // 3: round-robin rotation across all three producers
    set_src(3'b111, 5'd1, 5'd2, 5'd3, 32'h100, 32'h101, 32'h102);
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("t3_gnt%0d", k), 32'(rr_ready), 32'(1 << (k % 3)));
      tick();
      chk($sformatf("t3_we%0d", k), 32'(rr_we), 32'd1);
      chk($sformatf("t3_waddr%0d", k), 32'(rr_waddr), 32'((k % 3) + 1));
    end
    set_src(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    chk("t3_bvec", rr_bvec, 32'd0);
    tick();

    // 4: fixed priority starves src2 until src0 drops
    set_src(3'b101, 5'd4, 5'd0, 5'd6, 32'h44, 32'h0, 32'h66);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("t4_gnt%0d", k), 32'(fp_ready), 32'b001);
      tick();
      chk($sformatf("t4_waddr%0d", k), 32'(fp_waddr), 32'd4);
    end
    set_src(3'b100, 5'd4, 5'd0, 5'd6, 32'h44, 32'h0, 32'h66);
    #1;
    chk("t4_gnt_src2", 32'(fp_ready), 32'b100);
    tick();
    set_src(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    chk("t4_we", 32'(fp_we), 32'd1);
    chk("t4_waddr", 32'(fp_waddr), 32'd6);
    chk("t4_wdata", fp_wdata, 32'h66);
    tick();

    // 5: WAW claim on r7 stalls while the MDU retires the older write
    iss_valid = 1'b1;
    iss_addr  = 5'd7;
    #1;
    chk("t5_iss_first", 32'(rr_iss_rdy), 32'd1);
    tick();
    set_src(3'b100, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'h77);
    #1;
    chk("t5_iss_stall", 32'(rr_iss_rdy), 32'd0);
    chk("t5_mdu_rdy", 32'(rr_ready), 32'b100);
    tick();
    set_src(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    #1;
    chk("t5_iss_again", 32'(rr_iss_rdy), 32'd1);
    chk("t5_we", 32'(rr_we), 32'd1);
    chk("t5_waddr", 32'(rr_waddr), 32'd7);
    tick();
    iss_valid = 1'b0;
    #1;
    chk("t5_bvec", rr_bvec, 32'h0000_0080);

    // 6: writes and claims of r0 are accepted but have no effect
    set_src(3'b010, 5'd0, 5'd0, 5'd0, 32'h0, 32'h1234, 32'h0);
    iss_valid = 1'b1;
    iss_addr  = 5'd0;
    #1;
    chk("t6_lsu_rdy", 32'(rr_ready), 32'b010);
    chk("t6_iss_r0", 32'(rr_iss_rdy), 32'd1);
    tick();
    set_src(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    iss_valid = 1'b0;
    #1;
    chk("t6_we", 32'(rr_we), 32'd0);
    chk("t6_bvec", rr_bvec, 32'h0000_0080);

    // 7: reset right after a handshake discards the captured write
    iss_valid = 1'b1;
    iss_addr  = 5'd9;
    tick();
    iss_valid = 1'b0;
    set_src(3'b010, 5'd0, 5'd9, 5'd0, 32'h0, 32'h99, 32'h0);
    #1;
    chk("t7_bvec_pre", rr_bvec, 32'h0000_0280);
    chk("t7_lsu_rdy", 32'(rr_ready), 32'b010);
    tick();
    set_src(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    rst       = 1'b1;
    chk_addr1 = 5'd7;
    #1;
    chk("t7_busy1_rst", 32'(rr_busy1), 32'd0);
    tick();
    chk("t7_we", 32'(rr_we), 32'd0);
    chk("t7_bvec", rr_bvec, 32'd0);
    chk("t7_fp_bvec", fp_bvec, 32'd0);
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
